// File: rtl/slot_select_if.sv
// CPU-side bus bundle for the slot selector: Z80 strobes, address, write data and readback.
interface slot_select_if;
  logic [15:0] addr;
  logic [7:0]  d_from_cpu;
  logic        mreq_n;
  logic        iorq_n;
  logic        m1_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  d_to_cpu;
  logic        d_oe;

  modport master (
    output addr, d_from_cpu, mreq_n, iorq_n, m1_n, rd_n, wr_n,
    input  d_to_cpu, d_oe
  );

  modport slave (
    input  addr, d_from_cpu, mreq_n, iorq_n, m1_n, rd_n, wr_n,
    output d_to_cpu, d_oe
  );
endinterface

// File: rtl/slot_select.sv
// Primary/expanded slot selector: holds the 0xA8 and 0xFFFF registers and decodes each
// memory cycle into slot, subslot and cartridge chip selects.
module slot_select #(
  parameter int unsigned EXP_SLOT = 0,
  parameter logic [7:0]  IO_PORT  = 8'hA8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  slot_select_if.slave        bus,
  output logic [3:0]          SLTSL_n,
  output logic [3:0]          SUBSLT_n,
  output logic                CS1_n,
  output logic                CS01_n,
  output logic                CS12_n,
  output logic                CS2_n,
  output logic [7:0]          slot_reg,
  output logic [7:0]          subslot_reg
);

  localparam logic [1:0] ExpSel = EXP_SLOT[1:0];

  logic [7:0] slot_q, subslot_q;
  logic       port_wr_q, sub_wr_q;

  logic [1:0] page, pslot, sslot;
  logic       mem_active, rd_cycle, ffff_shadow, io_sel;
  logic       port_wr, sub_wr;

  always_comb begin
    page        = bus.addr[15:14];
    pslot       = slot_q[{page, 1'b0} +: 2];
    sslot       = subslot_q[{page, 1'b0} +: 2];
    mem_active  = !bus.mreq_n && (!bus.rd_n || !bus.wr_n);
    rd_cycle    = !bus.mreq_n && !bus.rd_n;
    ffff_shadow = (bus.addr == 16'hFFFF) && (slot_q[7:6] == ExpSel);
    // A simultaneous mreq takes priority, and M1 marks interrupt acknowledge.
    io_sel      = !bus.iorq_n && bus.mreq_n && bus.m1_n && (bus.addr[7:0] == IO_PORT);
    port_wr     = io_sel && !bus.wr_n;
    sub_wr      = mem_active && ffff_shadow && !bus.wr_n;
  end

  always_comb begin
    SLTSL_n  = 4'hF;
    SUBSLT_n = 4'hF;
    if (mem_active && !ffff_shadow) begin
      SLTSL_n[pslot] = 1'b0;
      if (pslot == ExpSel) SUBSLT_n[sslot] = 1'b0;
    end
  end

  always_comb begin
    CS1_n  = !(rd_cycle && (page == 2'd1));
    CS01_n = !(rd_cycle && !page[1]);
    CS12_n = !(rd_cycle && ((page == 2'd1) || (page == 2'd2)));
    CS2_n  = !(rd_cycle && (page == 2'd2));
  end

  always_comb begin
    bus.d_to_cpu = 8'hFF;
    bus.d_oe     = 1'b0;
    if (rd_cycle && ffff_shadow) begin
      bus.d_to_cpu = ~subslot_q;
      bus.d_oe     = 1'b1;
    end else if (io_sel && !bus.rd_n) begin
      bus.d_to_cpu = slot_q;
      bus.d_oe     = 1'b1;
    end
  end

  // Edge detectors come out of reset "already seen" so a strobe held across reset
  // must be released before it can commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= 8'h00;
      subslot_q <= 8'h00;
      port_wr_q <= 1'b1;
      sub_wr_q  <= 1'b1;
    end else if (clk_en) begin
      port_wr_q <= port_wr;
      sub_wr_q  <= sub_wr;
      if (port_wr && !port_wr_q) slot_q    <= bus.d_from_cpu;
      if (sub_wr && !sub_wr_q)   subslot_q <= bus.d_from_cpu;
    end
  end

  assign slot_reg    = slot_q;
  assign subslot_reg = subslot_q;

endmodule

// File: tb/tb_slot_select.sv
// Directed bench for slot_select: table-driven decode vectors plus hand-written write sequences.
module tb_slot_select;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic [3:0] SLTSL_n, SUBSLT_n;
  logic       CS1_n, CS01_n, CS12_n, CS2_n;
  logic [7:0] slot_reg, subslot_reg;

  int n_checks = 0;
  int n_pass   = 0;

  slot_select_if bus();

  slot_select #(.EXP_SLOT(0), .IO_PORT(8'hA8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .bus         (bus),
    .SLTSL_n     (SLTSL_n),
    .SUBSLT_n    (SUBSLT_n),
    .CS1_n       (CS1_n),
    .CS01_n      (CS01_n),
    .CS12_n      (CS12_n),
    .CS2_n       (CS2_n),
    .slot_reg    (slot_reg),
    .subslot_reg (subslot_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        mreq_n, iorq_n, m1_n, rd_n, wr_n;
    logic [3:0]  sltsl, subslt;
    logic [3:0]  cs;    // {CS1_n, CS01_n, CS12_n, CS2_n}
    logic        oe;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [15:0] a, input logic mq, input logic iq,
                              input logic m1, input logic rd, input logic wr,
                              input logic [3:0] sl, input logic [3:0] ss,
                              input logic [3:0] cs, input logic oe, input logic [7:0] d);
    vec_t v;
    v.addr = a; v.mreq_n = mq; v.iorq_n = iq; v.m1_n = m1; v.rd_n = rd; v.wr_n = wr;
    v.sltsl = sl; v.subslt = ss; v.cs = cs; v.oe = oe; v.dout = d;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.addr = 16'h0000; bus.d_from_cpu = 8'h00;
    bus.mreq_n = 1'b1; bus.iorq_n = 1'b1; bus.m1_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  task automatic io_wr(input logic [7:0] d);
    bus.addr = 16'h00A8; bus.d_from_cpu = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    step(); step();
    idle();
    step();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.addr = vecs[i].addr; bus.mreq_n = vecs[i].mreq_n; bus.iorq_n = vecs[i].iorq_n;
      bus.m1_n = vecs[i].m1_n; bus.rd_n = vecs[i].rd_n; bus.wr_n = vecs[i].wr_n;
      @(negedge clk);
      chk($sformatf("vec%0d sltsl", i), {12'h0, SLTSL_n}, {12'h0, vecs[i].sltsl});
      chk($sformatf("vec%0d subslt", i), {12'h0, SUBSLT_n}, {12'h0, vecs[i].subslt});
      chk($sformatf("vec%0d cs", i), {12'h0, CS1_n, CS01_n, CS12_n, CS2_n},
          {12'h0, vecs[i].cs});
      chk($sformatf("vec%0d oe/dout", i), {7'h0, bus.d_oe, bus.d_to_cpu},
          {7'h0, vecs[i].oe, vecs[i].dout});
      step();
    end
    idle();
    step();
  endtask

  initial begin
    // slot 00 / sub 00
    vecs[0]  = mk(16'h0000, 0, 1, 1, 0, 1, 4'b1110, 4'b1110, 4'b1011, 0, 8'hFF);
    // slot E4 / sub 00
    vecs[1]  = mk(16'h4000, 0, 1, 1, 0, 1, 4'b1101, 4'b1111, 4'b0001, 0, 8'hFF);
    vecs[2]  = mk(16'h8000, 0, 1, 1, 0, 1, 4'b1011, 4'b1111, 4'b1100, 0, 8'hFF);
    vecs[3]  = mk(16'hC000, 0, 1, 1, 0, 1, 4'b0111, 4'b1111, 4'b1111, 0, 8'hFF);
    vecs[4]  = mk(16'h00A8, 1, 0, 1, 0, 1, 4'b1111, 4'b1111, 4'b1111, 1, 8'hE4);
    vecs[5]  = mk(16'h0000, 0, 1, 1, 1, 1, 4'b1111, 4'b1111, 4'b1111, 0, 8'hFF);
    vecs[6]  = mk(16'h00A8, 1, 0, 0, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 8'hFF);
    vecs[7]  = mk(16'h00A9, 1, 0, 1, 0, 1, 4'b1111, 4'b1111, 4'b1111, 0, 8'hFF);
    vecs[8]  = mk(16'h0000, 0, 1, 1, 1, 0, 4'b1110, 4'b1110, 4'b1111, 0, 8'hFF);
    vecs[9]  = mk(16'h00A8, 0, 0, 1, 0, 1, 4'b1110, 4'b1110, 4'b1011, 0, 8'hFF);
    // slot 00 / sub 1B
    vecs[10] = mk(16'hFFFF, 0, 1, 1, 0, 1, 4'b1111, 4'b1111, 4'b1111, 1, 8'hE4);
    vecs[11] = mk(16'h4000, 0, 1, 1, 0, 1, 4'b1110, 4'b1011, 4'b0001, 0, 8'hFF);
    vecs[12] = mk(16'hC000, 0, 1, 1, 0, 1, 4'b1110, 4'b1110, 4'b1111, 0, 8'hFF);
    vecs[13] = mk(16'h8000, 0, 1, 1, 0, 1, 4'b1110, 4'b1101, 4'b1100, 0, 8'hFF);
    vecs[14] = mk(16'h0000, 0, 1, 1, 0, 1, 4'b1110, 4'b0111, 4'b1011, 0, 8'hFF);

    idle();
    reset  = 1'b1;
    clk_en = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset slot_reg", {8'h0, slot_reg}, 16'h0000);
    chk("reset subslot_reg", {8'h0, subslot_reg}, 16'h0000);
    chk("reset sltsl", {12'h0, SLTSL_n}, 16'h000F);
    chk("reset subslt", {12'h0, SUBSLT_n}, 16'h000F);
    chk("reset cs", {12'h0, CS1_n, CS01_n, CS12_n, CS2_n}, 16'h000F);
    chk("reset oe/dout", {7'h0, bus.d_oe, bus.d_to_cpu}, 16'h00FF);
    reset = 1'b0;
    step(); step();

    run_vecs(0, 0);
    io_wr(8'hE4);
    chk("out A8 E4", {8'h0, slot_reg}, 16'h00E4);
    run_vecs(1, 9);

    io_wr(8'h00);
    bus.addr = 16'hFFFF; bus.d_from_cpu = 8'h1B; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    @(negedge clk);
    chk("ffff wr sltsl", {12'h0, SLTSL_n}, 16'h000F);
    chk("ffff wr subslt", {12'h0, SUBSLT_n}, 16'h000F);
    step(); step();
    idle();
    step();
    chk("ffff wr subslot_reg", {8'h0, subslot_reg}, 16'h001B);
    run_vecs(10, 14);

    // FFFF write with page 3 pointing at a non-expanded slot
    io_wr(8'hC0);
    bus.addr = 16'hFFFF; bus.d_from_cpu = 8'h55; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    @(negedge clk);
    chk("ffff normal sltsl", {12'h0, SLTSL_n}, 16'h0007);
    chk("ffff normal subslt", {12'h0, SUBSLT_n}, 16'h000F);
    step(); step();
    idle();
    step();
    chk("ffff normal subslot_reg", {8'h0, subslot_reg}, 16'h001B);

    // held strobe commits only its first value
    bus.addr = 16'h00A8; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.d_from_cpu = 8'h11;
    step(); step();
    bus.d_from_cpu = 8'h22;
    step(); step(); step();
    chk("held write", {8'h0, slot_reg}, 16'h0011);
    idle();
    step();
    chk("held write after release", {8'h0, slot_reg}, 16'h0011);

    // writes ignored without clk_en
    clk_en = 1'b0;
    bus.addr = 16'h00A8; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.d_from_cpu = 8'h77;
    step(); step(); step();
    idle();
    step();
    clk_en = 1'b1;
    step();
    chk("clk_en low", {8'h0, slot_reg}, 16'h0011);

    // reset while strobe held
    bus.addr = 16'h00A8; bus.iorq_n = 1'b0; bus.wr_n = 1'b0; bus.d_from_cpu = 8'h33;
    step(); step();
    chk("pre-reset write", {8'h0, slot_reg}, 16'h0033);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    chk("held across reset", {8'h0, slot_reg}, 16'h0000);
    idle();
    step();
    io_wr(8'h44);
    chk("rewrite after reset", {8'h0, slot_reg}, 16'h0044);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
